sseg_share_ctrl: RTL and testbench
==================================

Name: sseg_share_ctrl

Overview:
Arbitration and sequencing controller that shares the single 4-digit seven-segment display driver between two requesters (e.g. a counter value and a status/debug word). It grants the display round-robin with a minimum dwell time per owner and forwards the owner's 16-bit hex/BCD word as a registered value. It also generates a per-digit leading-zero blank mask that the scan driver ANDs into its anode outputs.

Parameters:
DWELL_CYCLES, 50_000_000, minimum cycles an owner keeps the display when the other requester is waiting; legal range >= 2.
LZ_BLANK, 1, 1 = blank leading zero digits; 0 = never blank while granted.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  synchronous, active-high reset
req  input  2  req[k] = requester k wants the display; level, held while wanted
num0  input  16  requester 0 display word, digit i = num0[4i+3:4i], digit 0 rightmost
num1  input  16  requester 1 display word, same format
grant  output  2  one-hot current owner; 2'b00 = idle
num_out  output  16  registered word to display driver
blank_out  output  4  blank_out[i]=1 -> digit i dark
busy  output  1  |grant

Behaviour:
- Everything registered, single clock domain, no combinational input-to-output path.
- Reset (rst=1 at edge, regardless of state): grant=00, num_out=16'h0000, blank_out=4'b1111, dwell counter=0, last_owner=1 (requester 0 wins the first tie). Reset mid-grant drops ownership at that edge.
- State: IDLE (grant=00) or OWN(k). Dwell counter width $clog2(DWELL_CYCLES); it clears on every grant edge and increments each cycle in OWN; it saturates at DWELL_CYCLES-1 ("expired").
- IDLE: if req!=00 at edge, grant the requester. If both request, grant the one != last_owner. grant, num_out<=num_k, blank_out, and last_owner all update at that same edge. Latency req->grant is 1 cycle. With req=00, stay IDLE: num_out is held, blank_out=1111.
- OWN(k), each edge, evaluated in this priority order:
  1. req[k]=0: release. If req[other]=1, grant the other at this edge (direct handover, no idle cycle). Otherwise go IDLE: grant=00, blank_out=1111.
  2. Counter expired and req[other]=1: switch to the other at this edge and clear the counter. The owner therefore holds grant exactly DWELL_CYCLES cycles when contended.
  3. Otherwise stay. num_out<=num_k every cycle, so a live value is tracked with 1-cycle latency. With no contender the owner keeps the display indefinitely.
- Early release (step 1) bypasses dwell; dwell only limits forced switches.
- Blank mask, computed from the value being loaded into num_out in the same edge:
  - With LZ_BLANK=1: blank_out[3] = (d3==0). blank_out[2] = (d3==0 && d2==0). blank_out[1] = (d3|d2|d1)==0.
  - blank_out[0]=0 whenever granted, so the value 0 shows as a single "0".
  - With LZ_BLANK=0: blank_out=0000 while granted.
  - In IDLE: blank_out=1111 irrespective of LZ_BLANK.
- grant is never 2'b11. A grant change and a num_out source change always occur at the same edge.
- Requester data is sampled only from the current/new owner; the other word is ignored.

Test Plan:
- Reset: rst=1 for 2 cycles, req=11 -> grant=00, num_out=0000, blank_out=1111, busy=0 throughout. Release rst -> grant=01 one edge later.
- Single owner, DWELL_CYCLES=8: req=01, num0=16'h0042 -> next edge grant=01, num_out=0042, blank_out=1100. After 20 cycles grant still 01. num0=16'h1234 -> one edge later num_out=1234, blank_out=0000. num0=0 -> blank_out=1110.
- Contention, DWELL_CYCLES=8: from IDLE after reset req=11, num0=0001, num1=0BEE -> grant=01 for exactly 8 cycles, then grant=10, num_out=0BEE, blank_out=1000. After 8 more cycles grant=01 again.
- Early release: owner 1 granted 3 cycles, req goes 11->01 -> next edge grant=01, num_out=num0, no idle cycle. Then req->00 -> next edge grant=00, blank_out=1111, busy=0.
- LZ_BLANK=0 build, num0=0000 granted -> blank_out=0000. IDLE -> 1111.
- Reset mid-operation: grant=10 with counter mid-dwell, rst pulse 1 cycle with req=11 -> grant=00 that edge, then grant=01 (last_owner reset to 1).

Source files
------------

// File: rtl/sseg_share_ctrl.sv
// Round-robin arbiter sharing one 4-digit seven-segment driver between two requesters,
// with minimum dwell per owner and a registered leading-zero blank mask.
module sseg_share_ctrl #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [15:0] num0,
  input  logic [15:0] num1,
  output logic [1:0]  grant,
  output logic [15:0] num_out,
  output logic [3:0]  blank_out,
  output logic        busy
);

  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

  // State encoding equals the one-hot grant value, so grant is the state register.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;

  logic [CNT_W-1:0] cnt;
  logic             last_owner;
  logic [1:0]       next_grant;
  logic [15:0]      sel_word;
  logic             expired;

  function automatic logic [3:0] blank_mask(input logic [15:0] w);
    logic [3:0] m;
    m = 4'b0000;
    if (LZ_BLANK) begin
      m[3] = (w[15:12] == 4'h0);
      m[2] = (w[15:8] == 8'h00);
      m[1] = (w[15:4] == 12'h000);
    end
    return m;
  endfunction

  assign expired = (cnt == CNT_MAX);

  always_comb begin
    next_grant = grant;
    case (grant)
      S_IDLE: begin
        if (req == 2'b11)
          next_grant = last_owner ? S_OWN0 : S_OWN1;
        else if (req[0])
          next_grant = S_OWN0;
        else if (req[1])
          next_grant = S_OWN1;
        else
          next_grant = S_IDLE;
      end
      S_OWN0: begin
        if (!req[0])
          next_grant = req[1] ? S_OWN1 : S_IDLE;
        else if (expired && req[1])
          next_grant = S_OWN1;
      end
      S_OWN1: begin
        if (!req[1])
          next_grant = req[0] ? S_OWN0 : S_IDLE;
        else if (expired && req[0])
          next_grant = S_OWN0;
      end
      default: next_grant = S_IDLE;
    endcase
  end

  assign sel_word = (next_grant == S_OWN1) ? num1 : num0;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= S_IDLE;
      num_out    <= 16'h0000;
      blank_out  <= 4'b1111;
      cnt        <= '0;
      last_owner <= 1'b1;
    end else begin
      grant <= next_grant;
      if (next_grant != S_IDLE) begin
        num_out    <= sel_word;
        blank_out  <= blank_mask(sel_word);
        last_owner <= (next_grant == S_OWN1);
        if (next_grant != grant)
          cnt <= '0;
        else if (!expired)
          cnt <= cnt + 1'b1;
      end else begin
        // Idle keeps the last word but darkens every digit.
        blank_out <= 4'b1111;
        cnt       <= '0;
      end
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_sseg_share_ctrl.sv
// Bench for sseg_share_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an owner/hold-time reference model.
module tb_sseg_share_ctrl;

  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] num0, num1;
  logic [1:0]  grant, grant_nl;
  logic [15:0] num_out, num_out_nl;
  logic [3:0]  blank_out, blank_out_nl;
  logic        busy, busy_nl;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: owner index (-1 = idle), cycles held, last owner, shown word.
  int          m_owner;
  int          m_held;
  int          m_last;
  logic [15:0] m_word;

  always #5 clk = ~clk;

  sseg_share_ctrl #(.DWELL_CYCLES(DWELL), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .num0(num0), .num1(num1),
    .grant(grant), .num_out(num_out), .blank_out(blank_out), .busy(busy)
  );

  sseg_share_ctrl #(.DWELL_CYCLES(DWELL), .LZ_BLANK(1'b0)) dut_nl (
    .clk(clk), .rst(rst), .req(req), .num0(num0), .num1(num1),
    .grant(grant_nl), .num_out(num_out_nl), .blank_out(blank_out_nl), .busy(busy_nl)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int k);
    return (k == 1) ? num1 : num0;
  endfunction

  task automatic model_step();
    int other;
    if (rst) begin
      m_owner = -1; m_held = 0; m_last = 1; m_word = 16'h0000;
    end else if (m_owner < 0) begin
      if (req == 2'b11)      m_owner = 1 - m_last;
      else if (req[0])       m_owner = 0;
      else if (req[1])       m_owner = 1;
      if (m_owner >= 0) m_held = 1;
    end else begin
      other = 1 - m_owner;
      if (!req[m_owner]) begin
        m_owner = req[other] ? other : -1;
        m_held  = 1;
      end else if (m_held >= DWELL && req[other]) begin
        m_owner = other;
        m_held  = 1;
      end else begin
        m_held++;
      end
    end
    if (!rst && m_owner >= 0) begin
      m_word = word_of(m_owner);
      m_last = m_owner;
    end
  endtask

  function automatic logic [3:0] exp_blank(input int owner, input logic [15:0] w, input bit lz);
    logic [3:0] b;
    bit all_zero;
    if (owner < 0) return 4'b1111;
    b = 4'b0000;
    if (lz) begin
      all_zero = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        all_zero = all_zero && (w[4*i +: 4] == 4'h0);
        b[i] = all_zero;
      end
    end
    return b;
  endfunction

  function automatic logic [1:0] exp_grant(input int owner);
    if (owner < 0) return 2'b00;
    return (owner == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'(exp_grant(m_owner)));
    chk({tag, ".num_out"}, 32'(num_out), 32'(m_word));
    chk({tag, ".blank"}, 32'(blank_out), 32'(exp_blank(m_owner, m_word, 1'b1)));
    chk({tag, ".blank_nolz"}, 32'(blank_out_nl), 32'(exp_blank(m_owner, m_word, 1'b0)));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
  endtask

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    logic [15:0] n0;
    logic [15:0] n1;
    logic [1:0]  g;
    logic [15:0] num;
    logic [3:0]  bl;
    logic [3:0]  bl_nl;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int sh;

    tbl[0]  = '{1'b1, 2'b11, 16'h0042, 16'h0BEE, 2'b00, 16'h0000, 4'b1111, 4'b1111};
    tbl[1]  = '{1'b1, 2'b11, 16'h0042, 16'h0BEE, 2'b00, 16'h0000, 4'b1111, 4'b1111};
    tbl[2]  = '{1'b0, 2'b11, 16'h0042, 16'h0BEE, 2'b01, 16'h0042, 4'b1100, 4'b0000};
    tbl[3]  = '{1'b0, 2'b01, 16'h1234, 16'h0BEE, 2'b01, 16'h1234, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 2'b01, 16'h0000, 16'h0BEE, 2'b01, 16'h0000, 4'b1110, 4'b0000};
    tbl[5]  = '{1'b0, 2'b01, 16'h0005, 16'h0BEE, 2'b01, 16'h0005, 4'b1110, 4'b0000};
    tbl[6]  = '{1'b0, 2'b00, 16'h0005, 16'h0BEE, 2'b00, 16'h0005, 4'b1111, 4'b1111};
    tbl[7]  = '{1'b0, 2'b10, 16'h0005, 16'h0BEE, 2'b10, 16'h0BEE, 4'b1000, 4'b0000};
    tbl[8]  = '{1'b0, 2'b00, 16'h0005, 16'h0BEE, 2'b00, 16'h0BEE, 4'b1111, 4'b1111};
    tbl[9]  = '{1'b0, 2'b11, 16'h0001, 16'h0BEE, 2'b01, 16'h0001, 4'b1110, 4'b0000};
    tbl[10] = '{1'b0, 2'b00, 16'h0001, 16'h0BEE, 2'b00, 16'h0001, 4'b1111, 4'b1111};

    rst = 1'b1; req = 2'b00; num0 = 16'h0000; num1 = 16'h0000;
    #1;

    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; num0 = tbl[i].n0; num1 = tbl[i].n1;
      tick();
      chk($sformatf("vec%0d.grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d.num_out", i), 32'(num_out), 32'(tbl[i].num));
      chk($sformatf("vec%0d.blank", i), 32'(blank_out), 32'(tbl[i].bl));
      chk($sformatf("vec%0d.blank_nolz", i), 32'(blank_out_nl), 32'(tbl[i].bl_nl));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].g != 2'b00));
    end

    // Uncontended owner keeps the display indefinitely.
    req = 2'b01; num0 = 16'h0042;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold.grant", 32'(grant), 32'h1);
    end

    // Contention: exactly DWELL cycles per owner.
    rst = 1'b1; req = 2'b11; tick(); rst = 1'b0;
    chk("cont.reset_grant", 32'(grant), 32'h0);
    num0 = 16'h0001; num1 = 16'h0BEE;
    for (int i = 0; i < DWELL; i++) begin
      tick();
      chk("cont.own0", 32'(grant), 32'h1);
    end
    tick();
    chk("cont.switch_grant", 32'(grant), 32'h2);
    chk("cont.switch_num", 32'(num_out), 32'h0BEE);
    chk("cont.switch_blank", 32'(blank_out), 32'h8);
    for (int i = 0; i < DWELL - 1; i++) begin
      tick();
      chk("cont.own1", 32'(grant), 32'h2);
    end
    tick();
    chk("cont.back_grant", 32'(grant), 32'h1);

    // Early release hands over directly, then release to idle.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 2'b10; tick();
    chk("early.own1", 32'(grant), 32'h2);
    req = 2'b11; tick(); tick();
    chk("early.still1", 32'(grant), 32'h2);
    req = 2'b01; tick();
    chk("early.handover_grant", 32'(grant), 32'h1);
    chk("early.handover_num", 32'(num_out), 32'h0001);
    req = 2'b00; tick();
    chk("early.idle_grant", 32'(grant), 32'h0);
    chk("early.idle_blank", 32'(blank_out), 32'hF);
    chk("early.idle_busy", 32'(busy), 32'h0);

    // Reset mid-dwell drops ownership and restores requester-0 priority.
    req = 2'b11; tick();
    chk("midrst.own1", 32'(grant), 32'h2);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst.grant", 32'(grant), 32'h0);
    chk("midrst.num", 32'(num_out), 32'h0);
    chk("midrst.blank", 32'(blank_out), 32'hF);
    tick();
    chk("midrst.regrant", 32'(grant), 32'h1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        sh = $urandom_range(0, 4);
        w = 16'($urandom);
        num0 = w >> (4 * sh);
      end
      if ($urandom_range(0, 3) == 0) begin
        sh = $urandom_range(0, 4);
        w = 16'($urandom);
        num1 = w >> (4 * sh);
      end
      tick();
      check_model("rand");
      chk("rand.no_double_grant", 32'(grant == 2'b11), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
